// File: rtl/dds_pkg.sv
// dds_pkg: shared DAC frame constants and the SPI driver state encoding.
package dds_pkg;
    localparam int DAC_FRAME_BITS = 16;
    localparam int DAC_DATA_BITS = 12;
    localparam logic [1:0] DAC_CTRL_BITS = 2'b00;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} dac_state_t;
endpackage

// File: rtl/dac_bit_timer.sv
// dac_bit_timer: counts CLK_DIV-cycle SCLK half-periods, strobing at the end of each high/low half.
module dac_bit_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk_rise,
    output logic sclk_fall
);
    logic [7:0] cnt;
    logic low;
    logic last;
    assign last = cnt == 8'(CLK_DIV - 1);
    assign sclk_fall = en && last && !low;
    assign sclk_rise = en && last && low;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt <= '0;
            low <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            low <= 1'b0;
        end else if (last) begin
            cnt <= '0;
            low <= !low;
        end else begin
            cnt <= cnt + 8'd1;
        end
endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: one-entry sample buffer feeding a 16-bit SPI frame serializer for a 12-bit DAC.
// Data leaves from the MSB of the shift register, so it drains to zero by the end of each frame.
module dac_spi_driver
    import dds_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DAC_DATA_BITS-1:0] amplitude,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     dac_sclk,
    output logic                     dac_sync_n,
    output logic                     dac_din,
    output logic                     busy
);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    dac_state_t state, state_nx;
    logic [DAC_DATA_BITS-1:0] hold, hold_nx;
    logic hold_full, hold_full_nx;
    logic [DAC_FRAME_BITS-1:0] sreg, sreg_nx;
    logic [3:0] bit_cnt, bit_cnt_nx;
    logic [7:0] gap_cnt, gap_cnt_nx;
    logic sclk_nx, sync_n_nx, sclk_rise, sclk_fall, accept, load;
    assign dac_din = sreg[DAC_FRAME_BITS-1];
    dac_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk(clk),
        .rst(rst),
        .en(state == SHIFT),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall)
    );
    always_comb begin
        state_nx = state;
        hold_nx = hold;
        hold_full_nx = hold_full;
        sreg_nx = sreg;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        sclk_nx = dac_sclk;
        sync_n_nx = dac_sync_n;
        accept = sample_valid && sample_ready;
        load = hold_full && (state == IDLE || (state == GAP && gap_cnt == GAP_LAST));
        if (accept) begin
            hold_nx = amplitude;
            hold_full_nx = 1'b1;
        end
        case (state)
            SHIFT: begin
                if (sclk_fall) sclk_nx = 1'b0;
                if (sclk_rise) begin
                    sclk_nx = 1'b1;
                    sreg_nx = {sreg[DAC_FRAME_BITS-2:0], 1'b0};
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        state_nx = GAP;
                        sync_n_nx = 1'b1;
                        gap_cnt_nx = '0;
                    end
                end
            end
            GAP: begin
                state_nx = gap_cnt == GAP_LAST ? IDLE : GAP;
                gap_cnt_nx = gap_cnt + 8'd1;
            end
            default: ;
        endcase
        if (load) begin
            state_nx = SHIFT;
            hold_full_nx = 1'b0;
            sreg_nx = {2'b00, DAC_CTRL_BITS, hold};
            bit_cnt_nx = '0;
            sclk_nx = 1'b1;
            sync_n_nx = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            hold <= '0;
            hold_full <= 1'b0;
            sreg <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            dac_sclk <= 1'b1;
            dac_sync_n <= 1'b1;
            busy <= 1'b0;
            sample_ready <= 1'b0;
        end else begin
            state <= state_nx;
            hold <= hold_nx;
            hold_full <= hold_full_nx;
            sreg <= sreg_nx;
            bit_cnt <= bit_cnt_nx;
            gap_cnt <= gap_cnt_nx;
            dac_sclk <= sclk_nx;
            dac_sync_n <= sync_n_nx;
            busy <= state_nx != IDLE;
            sample_ready <= !hold_full_nx;
        end
endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: two DUTs (CLK_DIV/GAP 2/2 and 1/1) with a frame-timing reference model and scoreboard.
module tb_dac_spi_driver;
    typedef struct {
        logic [15:0] word;
        int start;
    } exp_t;
    logic clk = 0;
    logic rst = 1;
    logic d_vld = 0, s_vld = 0, s_stop = 0;
    logic [11:0] d_amp = 0, s_amp = 0;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = !clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int CD = g == 0 ? 2 : 1;
        localparam int GP = g == 0 ? 2 : 1;
        logic rdy, sclk, syncn, din, bsy;
        exp_t q[$];
        exp_t cur;
        int next_free = 0, pushed = 0, popped = 0, nb = 0, f_edge = 0, s;
        logic in_frame = 0, p_sync = 1, p_sclk = 1, p_din = 0;
        logic [15:0] word = 0;
        dac_spi_driver #(.CLK_DIV(CD), .GAP_CYCLES(GP)) dut (
            .clk(clk),
            .rst(rst),
            .amplitude(g == 0 ? d_amp : s_amp),
            .sample_valid(g == 0 ? d_vld : s_vld),
            .sample_ready(rdy),
            .dac_sclk(sclk),
            .dac_sync_n(syncn),
            .dac_din(din),
            .busy(bsy)
        );
        // Reference: a frame starts one edge after accept, but never before the previous frame plus its gap ends.
        always @(posedge clk) begin
            if (!rst) begin
                q.delete();
                next_free = 0;
                popped = pushed;
            end else if ((g == 0 ? d_vld : s_vld) && rdy) begin
                s = cyc + 1 > next_free ? cyc + 1 : next_free;
                q.push_back('{{4'b0000, g == 0 ? d_amp : s_amp}, s});
                pushed++;
                next_free = s + 32 * CD + GP;
            end
        end
        always @(negedge clk) begin
            if (!rst) begin
                in_frame = 0;
                nb = 0;
            end else begin
                if (p_sync && !syncn) begin
                    in_frame = 1;
                    nb = 0;
                    word = 0;
                    f_edge = cyc - 1;
                    check($sformatf("lane%0d_busy_in_frame", g), int'(bsy), 1);
                    if (q.size() == 0) begin
                        check($sformatf("lane%0d_frame_expected", g), 0, 1);
                        cur = '{16'h0, 0};
                    end else begin
                        cur = q.pop_front();
                        popped++;
                        check($sformatf("lane%0d_frame_start_edge", g), f_edge, cur.start);
                    end
                end
                if (!syncn && p_sclk && !sclk) begin
                    word = {word[14:0], din};
                    nb++;
                end
                if (din != p_din)
                    check($sformatf("lane%0d_din_moves_on_sclk_rise", g),
                          int'((!p_sclk && sclk) || (syncn != p_sync)), 1);
                if (!p_sync && syncn && in_frame) begin
                    in_frame = 0;
                    check($sformatf("lane%0d_falling_edges", g), nb, 16);
                    check($sformatf("lane%0d_frame_word", g), int'(word), int'(cur.word));
                    check($sformatf("lane%0d_sync_low_cycles", g), cyc - 1 - f_edge, 32 * CD);
                    check($sformatf("lane%0d_idle_din_zero", g), int'(din), 0);
                end
            end
            p_sync = syncn;
            p_sclk = sclk;
            p_din = din;
        end
    end
    initial forever begin
        @(negedge clk);
        s_vld = !s_stop;
        s_amp = 12'($urandom);
    end
    task automatic send(input logic [11:0] a, output int acc);
        int n = 0;
        d_amp = a;
        d_vld = 1;
        while (!lane[0].rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        d_vld = 0;
        acc = cyc - 1;
        if (n >= 500) check("send_ready_timeout", n, 0);
    endtask
    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((lane[0].bsy || !lane[0].rdy || lane[1].bsy || !lane[1].rdy) && n < 2000);
        if (n >= 2000) check("idle_timeout", n, 0);
    endtask
    task automatic reset_release();
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #1 check("ready_after_reset", int'(lane[0].rdy), 1);
        check("busy_after_reset", int'(lane[0].bsy), 0);
    endtask
    initial begin
        int e1, e2, e3, lows;
        s_stop = 1;
        #3 rst = 0;
        #1 check("rst_sclk", int'(lane[0].sclk), 1);
        check("rst_sync_n", int'(lane[0].syncn), 1);
        check("rst_din", int'(lane[0].din), 0);
        check("rst_busy", int'(lane[0].bsy), 0);
        check("rst_ready", int'(lane[0].rdy), 0);
        reset_release();
        @(negedge clk);
        send(12'hA5C, e1);
        wait_idle();
        send(12'h000, e1);
        send(12'hFFF, e2);
        wait_idle();
        send(12'h123, e1);
        send(12'h456, e2);
        send(12'h789, e3);
        check("second_accept_offset", e2 - e1, 2);
        check("third_accept_offset", e3 - e1, 68);
        wait_idle();
        check("idle_busy", int'(lane[0].bsy), 0);
        send(12'h3C7, e1);
        repeat (34) @(posedge clk);
        #2 rst = 0;
        #1 check("midframe_rst_sync_n", int'(lane[0].syncn), 1);
        check("midframe_rst_sclk", int'(lane[0].sclk), 1);
        check("midframe_rst_din", int'(lane[0].din), 0);
        check("midframe_rst_busy", int'(lane[0].bsy), 0);
        check("midframe_rst_ready", int'(lane[0].rdy), 0);
        reset_release();
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!lane[0].syncn) lows++;
        end
        check("no_resumed_frame", lows, 0);
        s_stop = 0;
        repeat (3000) begin
            @(negedge clk);
            d_vld = $urandom_range(0, 15) == 0;
            d_amp = 12'($urandom);
        end
        d_vld = 0;
        s_stop = 1;
        @(negedge clk);
        wait_idle();
        repeat (4) @(negedge clk);
        check("lane0_all_frames_sent", lane[0].popped, lane[0].pushed);
        check("lane1_all_frames_sent", lane[1].popped, lane[1].pushed);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
